// File: rtl/ahb_apb_bridge_top.sv
// AHB-Lite to APB bridge: pipelines AHB address/data and converts each beat
// into an APB SETUP/ACCESS pair for three fixed-address slaves.
module ahb_apb_bridge_top (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] HWdata,
    input  logic [31:0] PRdata,
    output logic        Penable,
    output logic        Pwrite,
    output logic [2:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] PWdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp,
    output logic [31:0] HRdata
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE,
        ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP
    } state_t;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // 64 MB windows starting at 0x8000_0000
    function automatic logic [2:0] decode(input logic [31:0] a);
        case (a[31:26])
            6'b100000: decode = 3'b001;
            6'b100001: decode = 3'b010;
            6'b100010: decode = 3'b100;
            default:   decode = 3'b000;
        endcase
    endfunction

    state_t      state, next_state;
    logic [31:0] haddr1, haddr2, hwdata1;
    logic        hwritereg;
    logic [2:0]  tempselx;
    logic        valid;

    logic        penable_n, pwrite_n, hreadyout_n;
    logic [2:0]  pselx_n;
    logic [31:0] paddr_n, pwdata_n;

    assign tempselx = decode(Haddr);
    assign valid    = Hreadyin && (Htrans == TR_NONSEQ || Htrans == TR_SEQ) && (tempselx != 3'b000);
    assign Hresp    = 2'b00;
    assign HRdata   = PRdata;

    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            haddr1    <= '0;
            haddr2    <= '0;
            hwdata1   <= '0;
            hwritereg <= 1'b0;
        end else begin
            haddr1    <= Haddr;
            haddr2    <= haddr1;
            hwdata1   <= HWdata;
            hwritereg <= Hwrite;
        end
    end

    // State and registered APB/AHB outputs
    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            state     <= ST_IDLE;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Pselx     <= 3'b000;
            Paddr     <= '0;
            PWdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            state     <= next_state;
            Penable   <= penable_n;
            Pwrite    <= pwrite_n;
            Pselx     <= pselx_n;
            Paddr     <= paddr_n;
            PWdata    <= pwdata_n;
            Hreadyout <= hreadyout_n;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (valid) next_state = Hwrite ? ST_WWAIT : ST_READ;
            ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     next_state = ST_RENABLE;
            ST_WRITE:    next_state = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   next_state = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE:  next_state = !valid ? ST_IDLE : (Hwrite ? ST_WWAIT : ST_READ);
            ST_WENABLEP: next_state = !hwritereg ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
            default:     next_state = ST_IDLE;
        endcase
    end

    // Output values loaded on the edge that enters next_state
    always_comb begin
        penable_n   = Penable;
        pwrite_n    = Pwrite;
        pselx_n     = Pselx;
        paddr_n     = Paddr;
        pwdata_n    = PWdata;
        hreadyout_n = Hreadyout;
        case (next_state)
            ST_READ: begin
                pselx_n = tempselx; paddr_n = Haddr; pwrite_n = 1'b0;
                penable_n = 1'b0; hreadyout_n = 1'b0;
            end
            ST_RENABLE, ST_WENABLE: begin
                penable_n = 1'b1; hreadyout_n = 1'b1;
            end
            ST_WRITE: begin
                pselx_n = decode(haddr1); paddr_n = haddr1; pwdata_n = HWdata;
                pwrite_n = 1'b1; penable_n = 1'b0; hreadyout_n = 1'b1;
            end
            ST_WRITEP: begin
                pselx_n = decode(haddr2); paddr_n = haddr2; pwdata_n = hwdata1;
                pwrite_n = 1'b1; penable_n = 1'b0; hreadyout_n = 1'b0;
            end
            ST_WENABLEP: begin
                penable_n = 1'b1; hreadyout_n = 1'b0;
            end
            ST_IDLE, ST_WWAIT: begin
                pselx_n = 3'b000; penable_n = 1'b0; hreadyout_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_apb_bridge_top.sv
// Directed bench for ahb_apb_bridge_top: cycle-by-cycle vectors with
// hand-computed APB outputs for reset, single transfers, decode and bursts.
module tb_ahb_apb_bridge_top;

    logic        Hclk = 1'b0;
    logic        Hresetn, Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr, HWdata, PRdata;
    logic        Penable, Pwrite, Hreadyout;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, PWdata, HRdata;
    logic [1:0]  Hresp;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

    ahb_apb_bridge_top dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .HWdata(HWdata), .PRdata(PRdata),
        .Penable(Penable), .Pwrite(Pwrite), .Pselx(Pselx), .Paddr(Paddr),
        .PWdata(PWdata), .Hreadyout(Hreadyout), .Hresp(Hresp), .HRdata(HRdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic step;
        @(posedge Hclk);
        #1;
    endtask

    task automatic drv(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [31:0] d);
        Haddr = a; Htrans = t; Hwrite = w; HWdata = d;
    endtask

    task automatic test_reset;
        Hresetn = 1'b1;
        drv(32'h0, IDL, 1'b0, 32'h0);
        Hreadyin = 1'b1; PRdata = 32'h0;
        step;
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout, Hresp} !== 8'b000_0_0_1_00) begin errors++; $display("FAIL reset_ctl got %b want 00000100", {Pselx, Penable, Pwrite, Hreadyout, Hresp}); end
        checks++; if ({Paddr, PWdata} !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", {Paddr, PWdata}); end
        Hresetn = 1'b0;
        step;
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL reset_idle got %b want 00001", {Pselx, Penable, Hreadyout}); end
    endtask

    task automatic test_single_write;
        drv(32'h8000_0000, NSQ, 1'b1, 32'h0);
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL wr_addr_ph got %b want 00001", {Pselx, Penable, Hreadyout}); end
        step;
        drv(32'h0, IDL, 1'b0, 32'hA5A5_0001);
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL wr_wwait got %b want 00001", {Pselx, Penable, Hreadyout}); end
        step;
        drv(32'h0, IDL, 1'b0, 32'h0);
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b001_0_1_1) begin errors++; $display("FAIL wr_setup_ctl got %b want 001011", {Pselx, Penable, Pwrite, Hreadyout}); end
        checks++; if ({Paddr, PWdata} !== {32'h8000_0000, 32'hA5A5_0001}) begin errors++; $display("FAIL wr_setup_data got %h want 80000000a5a50001", {Paddr, PWdata}); end
        step;
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b001_1_1_1) begin errors++; $display("FAIL wr_access_ctl got %b want 001111", {Pselx, Penable, Pwrite, Hreadyout}); end
        checks++; if ({Paddr, PWdata} !== {32'h8000_0000, 32'hA5A5_0001}) begin errors++; $display("FAIL wr_access_data got %h want 80000000a5a50001", {Paddr, PWdata}); end
        step;
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL wr_done got %b want 00001", {Pselx, Penable, Hreadyout}); end
    endtask

    task automatic test_single_read;
        drv(32'h8400_0010, NSQ, 1'b0, 32'h0);
        PRdata = 32'h1234_5678;
        step;
        drv(32'h0, IDL, 1'b0, 32'h0);
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b010_0_0_0) begin errors++; $display("FAIL rd_setup_ctl got %b want 010000", {Pselx, Penable, Pwrite, Hreadyout}); end
        checks++; if (Paddr !== 32'h8400_0010) begin errors++; $display("FAIL rd_setup_addr got %h want 84000010", Paddr); end
        step;
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b010_1_0_1) begin errors++; $display("FAIL rd_access_ctl got %b want 010101", {Pselx, Penable, Pwrite, Hreadyout}); end
        checks++; if (HRdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hrdata got %h want 12345678", HRdata); end
        step;
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL rd_done got %b want 00001", {Pselx, Penable, Hreadyout}); end
        PRdata = 32'hCAFE_0001;
        #1;
        checks++; if (HRdata !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_passthru got %h want cafe0001", HRdata); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] ad [0:3] = '{32'h9000_0000, 32'h8000_0000, 32'h8C00_0000, 32'h8400_0000};
        logic [1:0]  tr [0:3] = '{NSQ, IDL, SQ, BSY};
        for (int i = 0; i < 4; i++) begin
            drv(ad[i], tr[i], i[0], 32'h1111_0000);
            step;
            checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL oor_%0d got %b want 00001", i, {Pselx, Penable, Hreadyout}); end
        end
        drv(32'h8000_0000, NSQ, 1'b1, 32'h0);
        Hreadyin = 1'b0;
        step;
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin errors++; $display("FAIL oor_hreadyin got %b want 00001", {Pselx, Penable, Hreadyout}); end
        Hreadyin = 1'b1;
        drv(32'h0, IDL, 1'b0, 32'h0);
        step;
    endtask

    // Beats alternate WRITEP/WENABLEP; the last beat drains through WRITE/WENABLE.
    task automatic test_burst_write;
        logic [31:0] ad [0:10] = '{32'h8800_0000, 32'h8800_0004, 32'h8800_0004, 32'h8800_0008, 32'h8800_0008,
                                   32'h8800_000C, 32'h8800_000C, 32'h8800_000C, 32'h0, 32'h0, 32'h0};
        logic [1:0]  tr [0:10] = '{NSQ, SQ, SQ, SQ, SQ, SQ, SQ, IDL, IDL, IDL, IDL};
        logic [31:0] wd [0:10] = '{1, 1, 2, 2, 3, 3, 4, 4, 0, 0, 0};
        logic [4:0]  ec [0:10] = '{5'b000_0_1, 5'b000_0_1, 5'b100_0_0, 5'b100_1_0, 5'b100_0_0, 5'b100_1_0,
                                   5'b100_0_0, 5'b100_1_0, 5'b100_0_1, 5'b100_1_1, 5'b000_0_1};
        logic [31:0] ea [0:10] = '{0, 0, 32'h8800_0000, 32'h8800_0000, 32'h8800_0004, 32'h8800_0004,
                                   32'h8800_0008, 32'h8800_0008, 32'h8800_000C, 32'h8800_000C, 0};
        logic [31:0] ed [0:10] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0};
        drv(32'h8800_0000, IDL, 1'b1, 32'h0);
        step;
        for (int c = 0; c < 11; c++) begin
            drv(ad[c], tr[c], 1'b1, wd[c]);
            checks++; if ({Pselx, Penable, Hreadyout} !== ec[c]) begin errors++; $display("FAIL burst_ctl_c%0d got %b want %b", c, {Pselx, Penable, Hreadyout}, ec[c]); end
            if (c >= 2 && c <= 9) begin
                checks++; if ({Pwrite, Paddr, PWdata} !== {1'b1, ea[c], ed[c]}) begin errors++; $display("FAIL burst_xfer_c%0d got %b/%h/%h want 1/%h/%h", c, Pwrite, Paddr, PWdata, ea[c], ed[c]); end
            end
            step;
        end
    endtask

    task automatic test_reset_mid_burst;
        drv(32'h8800_0000, IDL, 1'b1, 32'h0);
        step;
        drv(32'h8800_0000, NSQ, 1'b1, 32'h1); step;
        drv(32'h8800_0004, SQ, 1'b1, 32'h1);  step;
        drv(32'h8800_0004, SQ, 1'b1, 32'h2);  step;
        drv(32'h8800_0008, SQ, 1'b1, 32'h2);
        checks++; if ({Pselx, Penable, Hreadyout} !== 5'b100_1_0) begin errors++; $display("FAIL midrst_access got %b want 10010", {Pselx, Penable, Hreadyout}); end
        Hresetn = 1'b1;
        #1;
        checks++; if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b000_0_0_1) begin errors++; $display("FAIL midrst_ctl got %b want 000001", {Pselx, Penable, Pwrite, Hreadyout}); end
        checks++; if ({Paddr, PWdata} !== 64'h0) begin errors++; $display("FAIL midrst_data got %h want 0", {Paddr, PWdata}); end
        drv(32'h0, IDL, 1'b0, 32'h0);
        step;
        Hresetn = 1'b0;
        test_single_write();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_out_of_range();
        test_burst_write();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
